regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter INIT_MODE, default 1, reset contents: 0 = all zero, 1 = register i holds value i (truncated to DATA_W).
REQ-004 SHALL have parameter BYPASS, default 1, where 1 = write-through forwarding on read ports and 0 = no forwarding.
REQ-005 SHALL have ports: CLK input 1, sole clock, all state updates on rising edge.
REQ-006 SHALL have ports: RST input 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: rs_rt input 2*ADDR_W, read addresses, rs = upper ADDR_W bits, rt = lower ADDR_W bits.
REQ-008 SHALL have ports: val_rs / val_rt output DATA_W each, read data.
REQ-009 SHALL have ports: rs_busy / rt_busy output 1 each, source register has an outstanding reservation.
REQ-010 SHALL have ports: we input 1, write enable; rwd input ADDR_W, write address; wb_data input DATA_W, write data.
REQ-011 SHALL have ports: rsv_en input 1, reserve request; rsv_addr input ADDR_W, destination register being issued.
REQ-012 SHALL have ports: pend_cnt output ADDR_W+1, number of registers currently reserved.

Function
REQ-013 SHALL read combinationally: val_rs = regs[rs], val_rt = regs[rt].
REQ-014 SHALL, when BYPASS=1 and we=1 with rwd!=0 and rwd matching a read address, drive wb_data on that read port in the same cycle.
REQ-015 SHALL write regs[rwd] <= wb_data on the rising edge when we=1 and rwd!=0.
REQ-016 SHALL ignore writes to register 0; val_rs/val_rt for address 0 SHALL always be 0 regardless of INIT_MODE or bypass.
REQ-017 SHALL keep one pending bit per register; rsv_en=1 with rsv_addr!=0 sets pending[rsv_addr] on the rising edge.
REQ-018 SHALL clear pending[rwd] on the rising edge when we=1 and rwd!=0.
REQ-019 SHALL, when the same cycle has reserve and write to the same register, leave the pending bit set (new reservation wins) and still perform the data write.
REQ-020 SHALL ignore rsv_en for address 0; pending[0] SHALL be constant 0.
REQ-021 SHALL treat a reservation of an already-pending register as a no-op on the bit; pend_cnt SHALL not change.
REQ-022 SHALL treat a write to a non-pending register as a normal write; pending bits and pend_cnt SHALL be unchanged.
REQ-023 SHALL drive rs_busy = pending[rs] AND NOT (BYPASS=1 AND we AND rwd==rs AND rwd!=0); rt_busy likewise.
REQ-024 SHALL implement pend_cnt as a registered counter tracking the population of pending bits: +1 on a new set, -1 on a clear, net 0 when both occur on different registers.
REQ-025 SHALL ensure pend_cnt never exceeds 2**ADDR_W-1 and never wraps below 0.
REQ-026 SHALL have zero-cycle read latency and one-cycle write/reserve latency; data written at edge N SHALL be readable without bypass from edge N onward.

Reset
REQ-027 SHALL, when RST=1 at a rising edge, load all registers per INIT_MODE, clear all pending bits, and set pend_cnt=0.
REQ-028 SHALL give RST priority over we and rsv_en in the same cycle; a write or reserve presented with RST SHALL be discarded.
REQ-029 SHALL, after reset deassertion, drive rs_busy=rt_busy=0 and val_rs/val_rt equal to the INIT_MODE contents of the addressed registers.

Verification
REQ-030 SHALL cover: INIT_MODE=1, RST then rs_rt={5'd7,5'd31} -> val_rs=7, val_rt=31, busy=0, pend_cnt=0.
REQ-031 SHALL cover: we=1, rwd=0, wb_data=32'hFFFF_FFFF, read address 0 -> val_rs=0 before and after the edge.
REQ-032 SHALL cover: rsv_en on r5 -> next cycle rs=5 gives rs_busy=1, pend_cnt=1; then we on r5 with 32'h1234 -> rs_busy=0 and val_rs=32'h1234 in the same cycle (BYPASS=1); pend_cnt=0 after the edge.
REQ-033 SHALL cover: same cycle rsv_en r9 and we r9 = 32'hAA, with r9 already pending -> after the edge regs[9]=32'hAA, pending[9]=1, pend_cnt unchanged.
REQ-034 SHALL cover: reserve r1..r31 on consecutive cycles -> pend_cnt=31; RST asserted together with we r3 -> pend_cnt=0, all pending clear, regs[3]=3.
REQ-035 SHALL cover: BYPASS=0 with we r4 = 32'h55 -> val_rs for rs=4 shows the old value 4 until the edge and 32'h55 after it.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/reserve bus for the register file scoreboard
// Ports (master = issuing pipeline, slave = register file):
//   rs_rt            master->slave  packed read addresses, rs in upper half, rt in lower half
//   val_rs, val_rt   slave->master  read data
//   rs_busy, rt_busy slave->master  source register has an outstanding reservation
//   we, rwd, wb_data master->slave  write-back port
//   rsv_en, rsv_addr master->slave  destination reservation port
//   pend_cnt         slave->master  number of registers currently reserved
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [2*ADDR_W-1:0] rs_rt;
    logic [DATA_W-1:0]   val_rs;
    logic [DATA_W-1:0]   val_rt;
    logic                rs_busy;
    logic                rt_busy;
    logic                we;
    logic [ADDR_W-1:0]   rwd;
    logic [DATA_W-1:0]   wb_data;
    logic                rsv_en;
    logic [ADDR_W-1:0]   rsv_addr;
    logic [ADDR_W:0]     pend_cnt;

    modport master (
        output rs_rt, we, rwd, wb_data, rsv_en, rsv_addr,
        input  val_rs, val_rt, rs_busy, rt_busy, pend_cnt
    );

    modport slave (
        input  rs_rt, we, rwd, wb_data, rsv_en, rsv_addr,
        output val_rs, val_rt, rs_busy, rt_busy, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - two-read one-write register file with per-register reservation scoreboard
// Ports:
//   CLK  sole clock, all state updates on the rising edge
//   RST  synchronous active-high reset, reloads contents per INIT_MODE and clears all reservations
//   bus  slave side of regfile_scoreboard_if (read ports, write-back, reserve, busy flags, pend_cnt)
module regfile_scoreboard #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [ADDR_W:0]   cnt;

    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              wr_ok;
    logic              rsv_ok;
    logic              fwd_rs;
    logic              fwd_rt;
    logic              set_new;
    logic              clr_old;

    assign rs = bus.rs_rt[2*ADDR_W-1:ADDR_W];
    assign rt = bus.rs_rt[ADDR_W-1:0];

    always_comb begin
        wr_ok   = bus.we && (bus.rwd != '0);
        rsv_ok  = bus.rsv_en && (bus.rsv_addr != '0);
        fwd_rs  = (BYPASS != 0) && wr_ok && (bus.rwd == rs);
        fwd_rt  = (BYPASS != 0) && wr_ok && (bus.rwd == rt);
        // Population changes only on a genuine 0->1 or 1->0 transition. A write that
        // lands on a register being re-reserved in the same cycle leaves its bit set.
        set_new = rsv_ok && !pending[bus.rsv_addr];
        clr_old = wr_ok && pending[bus.rwd] && !(rsv_ok && (bus.rsv_addr == bus.rwd));
    end

    // Register 0 is hardwired to zero on the read side; its storage is never read out.
    always_comb begin
        bus.val_rs = '0;
        bus.val_rt = '0;
        if (rs != '0) begin
            bus.val_rs = fwd_rs ? bus.wb_data : regs[rs];
        end
        if (rt != '0) begin
            bus.val_rt = fwd_rt ? bus.wb_data : regs[rt];
        end
    end

    // A forwarded write-back resolves the hazard this cycle, so busy drops with it.
    assign bus.rs_busy  = pending[rs] && !fwd_rs;
    assign bus.rt_busy  = pending[rt] && !fwd_rt;
    assign bus.pend_cnt = cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (INIT_MODE == 1) ? DATA_W'(i) : '0;
            end
            pending <= '0;
            cnt     <= '0;
        end else begin
            if (wr_ok) begin
                regs[bus.rwd]    <= bus.wb_data;
                pending[bus.rwd] <= 1'b0;
            end
            // Later assignment wins, so a same-cycle reservation overrides the clear.
            if (rsv_ok) begin
                pending[bus.rsv_addr] <= 1'b1;
            end
            case ({set_new, clr_old})
                2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
